store_buffer: RTL and testbench

Write buffer between the execute/memory pipeline stage and the 64×16 data memory. It accepts stores from the pipeline into a small in-order FIFO and drains them into the memory's single address/write port whenever loads are not using it. It forwards the youngest buffered store data to loads that hit a pending address, so the pipeline always sees program-order memory contents.

---
 rtl/mem_pkg.sv | 12 +
 rtl/store_buffer_if.sv | 28 ++
 rtl/sb_fwd_select.sv | 30 +++
 rtl/store_buffer.sv | 104 ++++++++++
 tb/tb_store_buffer.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared constants and the buffered-store entry type for the data memory
// and the store buffer.
package mem_pkg;
    localparam int unsigned ADDR_W    = 6;
    localparam int unsigned DATA_W    = 16;
    localparam int unsigned MEM_WORDS = 64;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } sb_entry_t;
endpackage

// File: rtl/store_buffer_if.sv
// Pipeline-side and memory-side signals of the store buffer.
interface store_buffer_if;
    import mem_pkg::*;

    logic              st_valid;
    logic [ADDR_W-1:0] st_addr;
    logic [DATA_W-1:0] st_data;
    logic              st_ready;
    logic              ld_valid;
    logic [ADDR_W-1:0] ld_addr;
    logic              ld_ready;
    logic [DATA_W-1:0] ld_data;
    logic              empty;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  st_valid, st_addr, st_data, ld_valid, ld_addr, mem_rdata,
        output st_ready, ld_ready, ld_data, empty, mem_addr, mem_wdata, mem_we
    );

    modport master (
        output st_valid, st_addr, st_data, ld_valid, ld_addr, mem_rdata,
        input  st_ready, ld_ready, ld_data, empty, mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/sb_fwd_select.sv
// Finds the youngest valid buffered store whose address matches the load.
module sb_fwd_select
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  sb_entry_t         entries [DEPTH],
    input  logic [DEPTH-1:0]  valid,
    input  logic [PTR_W-1:0]  tail,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic              hit,
    output logic [DATA_W-1:0] data
);
    logic [PTR_W-1:0] idx;

    // Walk oldest to youngest starting at tail; later matches overwrite earlier ones.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = tail + PTR_W'(k);
            if (valid[idx] && entries[idx].addr == ld_addr) begin
                hit  = 1'b1;
                data = entries[idx].data;
            end
        end
    end
endmodule

// File: rtl/store_buffer.sv
// In-order write buffer between the pipeline and the data memory, draining
// when loads leave the memory port idle and forwarding pending store data.
module store_buffer
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    store_buffer_if.slave  sb
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    sb_entry_t        entries_q [DEPTH];
    sb_entry_t        entries_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             not_full;
    logic             push;
    logic             pop;
    logic             ld_grant;
    logic [DEPTH-1:0] valid;
    logic [PTR_W-1:0] rel;
    logic             fwd_hit;
    logic [DATA_W-1:0] fwd_data;

    always_comb begin
        not_full = (count_q != FULL);
        push     = !rst && sb.st_valid && not_full;
        // A full buffer drains even under a load so the stalled load can proceed next cycle.
        pop      = !rst && (count_q != '0) && (!sb.ld_valid || !not_full);
        ld_grant = !rst && sb.ld_valid && not_full;
    end

    always_comb begin
        valid = '0;
        rel   = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            rel      = PTR_W'(i) - head_q;
            valid[i] = ({1'b0, rel} < count_q);
        end
    end

    sb_fwd_select #(.DEPTH(DEPTH)) u_fwd (
        .entries (entries_q),
        .valid   (valid),
        .tail    (tail_q),
        .ld_addr (sb.ld_addr),
        .hit     (fwd_hit),
        .data    (fwd_data)
    );

    always_comb begin
        sb.st_ready  = !rst && not_full;
        sb.ld_ready  = !rst && not_full;
        sb.empty     = (count_q == '0);
        sb.mem_we    = pop;
        sb.mem_wdata = entries_q[head_q].data;
        sb.mem_addr  = entries_q[head_q].addr;
        if (!pop && ld_grant) begin
            sb.mem_addr = sb.ld_addr;
        end
        sb.ld_data   = fwd_hit ? fwd_data : sb.mem_rdata;
    end

    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        if (push) begin
            entries_d[tail_q] = '{addr: sb.st_addr, data: sb.st_data};
            tail_d            = tail_q + 1'b1;
        end
        if (pop) begin
            head_d = head_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        entries_q <= entries_d;
    end
endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: program-order memory model plus
// directed scenarios and a randomized store/load mix.
module tb_store_buffer;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    store_buffer_if bus();

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .sb  (bus)
    );

    logic [15:0] phys_mem [64];
    logic [15:0] ref_mem  [64];
    int          qa [$];
    int          qd [$];
    int          n_cmp = 0;
    int          n_bad = 0;

    assign bus.mem_rdata = phys_mem[bus.mem_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: stores become architecturally visible when accepted; the
    // pending queue predicts drain order and timing.
    int sz;
    bit exp_rdy, exp_we, ld_ok;
    always @(negedge clk) begin
        sz      = qa.size();
        exp_rdy = !rst && sz < DEPTH;
        exp_we  = !rst && sz != 0 && (!bus.ld_valid || sz == DEPTH);
        ld_ok   = bus.ld_valid && exp_rdy;
        check("st_ready", 32'(bus.st_ready), 32'(exp_rdy));
        check("ld_ready", 32'(bus.ld_ready), 32'(exp_rdy));
        check("empty",    32'(bus.empty),    32'(sz == 0));
        check("mem_we",   32'(bus.mem_we),   32'(exp_we));
        if (exp_we) begin
            check("drain_addr",  32'(bus.mem_addr),  32'(qa[0]));
            check("drain_wdata", 32'(bus.mem_wdata), 32'(qd[0]));
        end else if (ld_ok) begin
            check("load_addr", 32'(bus.mem_addr), 32'(bus.ld_addr));
        end else if (!rst && sz != 0) begin
            check("idle_addr", 32'(bus.mem_addr), 32'(qa[0]));
        end
        if (ld_ok) check("ld_data", 32'(bus.ld_data), 32'(ref_mem[bus.ld_addr]));

        if (rst) begin
            for (int i = 0; i < 64; i++) begin
                phys_mem[i] = '0;
                ref_mem[i]  = '0;
            end
            qa.delete();
            qd.delete();
        end else begin
            if (bus.mem_we) phys_mem[bus.mem_addr] = bus.mem_wdata;
            if (bus.st_valid && sz < DEPTH) begin
                ref_mem[bus.st_addr] = bus.st_data;
                qa.push_back(int'(bus.st_addr));
                qd.push_back(int'(bus.st_data));
            end
            if (exp_we) begin
                void'(qa.pop_front());
                void'(qd.pop_front());
            end
        end
    end

    task automatic drive(input bit sv, input int sa, input int sd, input bit lv, input int la);
        bus.st_valid = sv;
        bus.st_addr  = 6'(sa);
        bus.st_data  = 16'(sd);
        bus.ld_valid = lv;
        bus.ld_addr  = 6'(la);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_empty(input int budget);
        drive(0, 0, 0, 0, 0);
        for (int n = 0; n < budget; n++) begin
            look();
            if (bus.empty) break;
            step();
        end
        check("drain_done", 32'(bus.empty), 32'd1);
        step();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            phys_mem[i] = '0;
            ref_mem[i]  = '0;
        end
        drive(0, 0, 0, 0, 0);
        rst = 1'b1;
        look();
        check("rst_st_ready", 32'(bus.st_ready), 32'd0);
        check("rst_mem_we",   32'(bus.mem_we),   32'd0);
        step();
        step();
        rst = 1'b0;
        look();
        check("post_rst_ready", 32'({bus.st_ready, bus.ld_ready, bus.empty}), 32'b111);

        // single store drains on the next cycle
        step();
        drive(1, 5, 'h1234, 0, 0);
        step();
        drive(0, 0, 0, 0, 0);
        look();
        check("t1_we",   32'(bus.mem_we),    32'd1);
        check("t1_addr", 32'(bus.mem_addr),  32'd5);
        check("t1_data", 32'(bus.mem_wdata), 32'h1234);
        step();
        look();
        check("t1_mem",   32'(phys_mem[5]), 32'h1234);
        check("t1_empty", 32'(bus.empty),   32'd1);
        step();

        // repeated address, load held: youngest forwarding, in-order drain
        drive(1, 3, 'hAAAA, 1, 3);
        look();
        check("t2_old", 32'(bus.ld_data), 32'h0);
        step();
        drive(1, 3, 'hBBBB, 1, 3);
        look();
        check("t2_fwd_a", 32'(bus.ld_data), 32'hAAAA);
        check("t2_hold",  32'(bus.mem_we),  32'd0);
        step();
        drive(0, 0, 0, 1, 3);
        look();
        check("t2_fwd_b", 32'(bus.ld_data), 32'hBBBB);
        step();
        drive(0, 0, 0, 0, 0);
        look();
        check("t2_w1", 32'({bus.mem_we, bus.mem_wdata}), 32'h1AAAA);
        step();
        look();
        check("t2_w2", 32'({bus.mem_we, bus.mem_wdata}), 32'h1BBBB);
        step();
        look();
        check("t2_mem", 32'(phys_mem[3]), 32'hBBBB);
        step();

        // fill under a held load; one drain frees it
        for (int i = 0; i < 4; i++) begin
            drive(1, 10 + i, 'h100 + i, 1, 9);
            step();
        end
        drive(0, 0, 0, 1, 9);
        look();
        check("t3_full_rdy", 32'({bus.st_ready, bus.ld_ready}), 32'b00);
        check("t3_drain",    32'({bus.mem_we, bus.mem_addr}),   32'({1'b1, 6'd10}));
        step();
        look();
        check("t3_freed", 32'({bus.st_ready, bus.ld_ready, bus.mem_we}), 32'b110);
        step();
        wait_empty(20);

        // same-cycle store and load: load sees prior contents
        drive(1, 7, 'h0F0F, 1, 7);
        look();
        check("t4_same", 32'(bus.ld_data), 32'h0);
        step();
        drive(0, 0, 0, 1, 7);
        look();
        check("t4_next", 32'(bus.ld_data), 32'h0F0F);
        step();
        wait_empty(20);

        // continuous stream: overlap push/pop and wrap pointers
        for (int i = 0; i < 10; i++) begin
            drive(1, 20 + i, 'h1111 * (i + 1), 0, 0);
            look();
            if (i > 0) check("t5_stream", 32'({bus.mem_we, bus.mem_addr}), 32'({1'b1, 6'(19 + i)}));
            step();
        end
        drive(0, 0, 0, 0, 0);
        step();
        look();
        check("t5_empty", 32'(bus.empty),     32'd1);
        check("t5_last",  32'(phys_mem[29]),  32'hAAAA);
        check("t5_first", 32'(phys_mem[20]),  32'h1111);
        step();

        // reset with pending stores discards them
        for (int i = 0; i < 3; i++) begin
            drive(1, 40 + i, 'hC000 + i, 1, 0);
            step();
        end
        drive(0, 0, 0, 0, 0);
        rst = 1'b1;
        look();
        check("t6_rst_we", 32'(bus.mem_we), 32'd0);
        step();
        step();
        rst = 1'b0;
        look();
        check("t6_empty", 32'({bus.empty, bus.mem_we}), 32'b10);
        step();
        drive(0, 0, 0, 1, 5);
        look();
        check("t6_cleared", 32'(bus.ld_data), 32'h0);
        step();
        drive(0, 0, 0, 1, 41);
        look();
        check("t6_dropped", 32'(bus.ld_data), 32'h0);
        step();

        // randomized mix over a small address range to provoke hits
        for (int c = 0; c < 800; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            drive($urandom_range(0, 99) < 55, $urandom_range(0, 7), $urandom_range(0, 65535),
                  $urandom_range(0, 99) < 40, $urandom_range(0, 7));
            step();
        end
        rst = 1'b0;
        wait_empty(20);
        for (int i = 0; i < 64; i++) check("final_mem", 32'(phys_mem[i]), 32'(ref_mem[i]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
